// File: rtl/plic_pkg.sv
// Shared definitions for the PLIC interrupt gateway.
package plic_pkg;

  // Gateway request lifecycle: waiting for a request, request presented to
  // the target, request being serviced by the target.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CLAIMED = 2'd2
  } gateway_state_t;

  // Trigger mode encodings for edge_lvl_i.
  localparam logic GW_LEVEL = 1'b0;
  localparam logic GW_EDGE  = 1'b1;

endpackage

// File: rtl/plic_gateway.sv
// Per-source interrupt gateway: turns a raw interrupt line into at most one
// outstanding request, holds further requests until the target completes,
// and in edge mode queues edges that arrive while a request is in service.
module plic_gateway
  import plic_pkg::*;
#(
  parameter int MAX_PENDING_COUNT = 8,
  parameter int PENDING_CNT_BITS  = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  input  logic edge_lvl_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic ip_o
);

  // Saturation limit held one bit wider than the counter so the unclamped
  // sum can be compared without overflowing.
  localparam logic [PENDING_CNT_BITS:0] CNT_MAX =
    (PENDING_CNT_BITS+1)'(MAX_PENDING_COUNT);

  gateway_state_t              r_state;
  logic [PENDING_CNT_BITS-1:0] r_cnt;
  logic                        r_src_d;
  logic                        r_ip;

  logic                        w_edge_mode;
  logic                        w_edge;
  logic                        w_req;
  logic                        w_take;
  logic [PENDING_CNT_BITS:0]   w_cnt_sum;
  logic [PENDING_CNT_BITS-1:0] w_cnt_nxt;

  // Request detection and edge-counter next value. A fresh edge that is
  // consumed immediately cancels its own increment, so the count only holds
  // edges that could not be delivered yet. The sum cannot go negative: a take
  // in edge mode implies either an edge or a non-zero count.
  always_comb begin
    w_edge_mode = (edge_lvl_i == GW_EDGE);
    w_edge      = src_i & ~r_src_d;
    w_req       = w_edge_mode ? (w_edge | (r_cnt != '0)) : src_i;
    w_take      = (r_state == IDLE) & w_req;
    w_cnt_sum   = {1'b0, r_cnt}
                + {{PENDING_CNT_BITS{1'b0}}, w_edge_mode & w_edge}
                - {{PENDING_CNT_BITS{1'b0}}, w_edge_mode & w_take};
    w_cnt_nxt   = '0;
    if (w_edge_mode) begin
      if (w_cnt_sum > CNT_MAX) w_cnt_nxt = CNT_MAX[PENDING_CNT_BITS-1:0];
      else                     w_cnt_nxt = w_cnt_sum[PENDING_CNT_BITS-1:0];
    end
  end

  // Gateway FSM with registered ip_o, edge counter and source delay flop.
  // Handshakes not valid for the current state are simply ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_ip    <= 1'b0;
      r_cnt   <= '0;
      r_src_d <= 1'b0;
    end else begin
      r_src_d <= src_i;
      r_cnt   <= w_cnt_nxt;
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_state <= PENDING;
            r_ip    <= 1'b1;
          end
        end
        PENDING: begin
          if (claim_i) begin
            r_state <= CLAIMED;
            r_ip    <= 1'b0;
          end
        end
        CLAIMED: begin
          if (complete_i) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ip    <= 1'b0;
        end
      endcase
    end
  end

  assign ip_o = r_ip;

endmodule

// File: tb/tb_plic_gateway.sv
// Scoreboard bench for plic_gateway: stimulus pushes the model's expected
// ip_o for each clock, a monitor pops and compares after every rising edge.
module tb_plic_gateway;
  import plic_pkg::*;

  localparam int MAXP = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic src = 1'b0;
  logic mode = GW_LEVEL;
  logic claim = 1'b0;
  logic complete = 1'b0;
  logic ip;

  int n_cmp = 0;
  int n_bad = 0;
  int rises = 0;
  bit prev_ip = 1'b0;
  bit exp_q[$];

  // Reference model: request lifecycle phase and number of queued edges.
  int m_phase = 0;   // 0 waiting, 1 presented, 2 in service
  int m_q = 0;
  bit m_prev = 1'b0;

  always #5 clk = ~clk;

  plic_gateway #(.MAX_PENDING_COUNT(MAXP), .PENDING_CNT_BITS(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .src_i(src), .edge_lvl_i(mode),
    .claim_i(claim), .complete_i(complete), .ip_o(ip)
  );

  function automatic void model_reset();
    m_phase = 0; m_q = 0; m_prev = 1'b0;
  endfunction

  function automatic void model_step(bit s, bit md, bit cl, bit co);
    bit e = s && !m_prev;
    bit req;
    int backlog;
    if (md) req = e || (m_q > 0);
    else    req = s;
    backlog = md ? m_q + int'(e) : 0;
    case (m_phase)
      0: if (req) begin m_phase = 1; if (md) backlog = backlog - 1; end
      1: if (cl) m_phase = 2;
      2: if (co) m_phase = 0;
      default: m_phase = 0;
    endcase
    m_q = (backlog > MAXP) ? MAXP : backlog;
    m_prev = s;
  endfunction

  task automatic cyc(input bit s, input bit md, input bit cl, input bit co);
    @(negedge clk);
    src = s; mode = md; claim = cl; complete = co;
    model_step(s, md, cl, co);
    exp_q.push_back(m_phase == 1);
  endtask

  // Drive claim/complete as the model says the gateway needs them.
  task automatic serve_all(input bit s, input bit md, input int n);
    for (int i = 0; i < n; i++) begin
      if (m_phase == 1)      cyc(s, md, 1'b1, 1'b0);
      else if (m_phase == 2) cyc(s, md, 1'b0, 1'b1);
      else                   cyc(s, md, 1'b0, 1'b0);
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Monitor: compare ip_o shortly after each rising edge and count rises.
  initial begin
    bit e;
    forever begin
      @(posedge clk);
      #1;
      if (ip && !prev_ip) rises++;
      prev_ip = ip;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (ip !== e) begin
          n_bad++;
          $display("FAIL ip_o at %0t: got %b want %b", $time, ip, e);
        end
      end
    end
  end

  initial begin
    int r0;
    bit s, md;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ip", int'(ip), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Level mode: raise, claim, complete with source still high
    repeat (4) cyc(0, GW_LEVEL, 0, 0);
    repeat (4) cyc(1, GW_LEVEL, 0, 0);
    cyc(1, GW_LEVEL, 1, 0);
    repeat (4) cyc(1, GW_LEVEL, 0, 0);
    cyc(1, GW_LEVEL, 0, 1);
    repeat (3) cyc(1, GW_LEVEL, 0, 0);
    serve_all(0, GW_LEVEL, 6);

    // Ignored handshakes
    cyc(0, GW_LEVEL, 1, 1);
    cyc(0, GW_LEVEL, 1, 0);
    cyc(0, GW_LEVEL, 0, 1);
    cyc(1, GW_LEVEL, 0, 0);
    cyc(0, GW_LEVEL, 0, 1);
    cyc(0, GW_LEVEL, 0, 1);
    cyc(0, GW_LEVEL, 1, 1);
    cyc(0, GW_LEVEL, 1, 0);
    cyc(0, GW_LEVEL, 0, 1);
    repeat (3) cyc(0, GW_LEVEL, 0, 0);

    // Edge burst: 3 edges while in service -> 3 further requests
    repeat (2) cyc(0, GW_EDGE, 0, 0);
    r0 = rises;
    cyc(1, GW_EDGE, 0, 0);
    cyc(0, GW_EDGE, 1, 0);
    repeat (3) begin cyc(1, GW_EDGE, 0, 0); cyc(0, GW_EDGE, 0, 0); end
    serve_all(0, GW_EDGE, 40);
    check("burst_requests", rises - r0, 4);

    // Saturation: 12 edges in service -> only 8 further requests
    r0 = rises;
    cyc(1, GW_EDGE, 0, 0);
    cyc(0, GW_EDGE, 1, 0);
    repeat (12) begin cyc(1, GW_EDGE, 0, 0); cyc(0, GW_EDGE, 0, 0); end
    serve_all(0, GW_EDGE, 60);
    check("saturated_requests", rises - r0, 9);

    // Edge and consume together in IDLE with count 2
    r0 = rises;
    cyc(1, GW_EDGE, 0, 0);
    cyc(0, GW_EDGE, 1, 0);
    repeat (2) begin cyc(1, GW_EDGE, 0, 0); cyc(0, GW_EDGE, 0, 0); end
    cyc(0, GW_EDGE, 0, 1);
    cyc(1, GW_EDGE, 0, 0);
    serve_all(0, GW_EDGE, 30);
    check("edge_consume_requests", rises - r0, 4);

    // Async reset while PENDING drops ip_o without a clock edge
    cyc(1, GW_EDGE, 0, 0);
    cyc(0, GW_EDGE, 0, 0);
    @(posedge clk); #3;
    check("pending_before_reset", int'(ip), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_pending", int'(ip), 0);
    @(negedge clk);
    rst_n = 1'b1; src = 1'b0; claim = 1'b0; complete = 1'b0;
    model_reset();

    // Reset mid-CLAIMED with 5 queued edges; src high through release
    cyc(1, GW_EDGE, 0, 0);
    cyc(0, GW_EDGE, 1, 0);
    repeat (5) begin cyc(1, GW_EDGE, 0, 0); cyc(0, GW_EDGE, 0, 0); end
    cyc(1, GW_EDGE, 0, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_claimed", int'(ip), 0);
    repeat (2) @(negedge clk);
    r0 = rises;
    rst_n = 1'b1; src = 1'b1; mode = GW_EDGE; claim = 1'b0; complete = 1'b0;
    model_reset();
    model_step(1, GW_EDGE, 0, 0);
    exp_q.push_back(m_phase == 1);
    serve_all(1, GW_EDGE, 30);
    check("post_reset_requests", rises - r0, 1);

    // Randomized traffic with occasional mode changes
    s = 1'b0; md = GW_EDGE;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) md = ~md;
      if ($urandom_range(3) == 0) s = ~s;
      cyc(s, md, $urandom_range(3) == 0, $urandom_range(3) == 0);
    end
    serve_all(0, GW_EDGE, 40);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
